// File: rtl/i2c_slave_frame_assembler.sv
// i2c_slave_frame_assembler
// Collects op word, operand A and operand B from the I2C slave controller,
// builds one frame (folding add/sub into operand A) and hands it to the
// compute/display logic over a valid/ready handshake. Bad op words,
// inter-word timeouts and overruns are reported as a one-cycle error pulse
// with a sticky cause code.
module i2c_slave_frame_assembler #(
   parameter int WORD_W      = 32,
   parameter int OP_W        = 2,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   input  logic              frame_ready,
   output logic              frame_valid,
   output logic [OP_W-1:0]   frame_op,
   output logic [WORD_W-1:0] frame_a,
   output logic [WORD_W-1:0] frame_b,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic              busy,
   output logic [1:0]        state_out
);

   localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ERR_BAD_OP  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_A = 2'd1,
      GET_B = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [WORD_W-1:0] a_q, a_d;
   logic [WORD_W-1:0] b_q, b_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              frame_valid_q, frame_valid_d;
   logic [OP_W-1:0]   frame_op_q, frame_op_d;
   logic [WORD_W-1:0] frame_a_q, frame_a_d;
   logic [WORD_W-1:0] frame_b_q, frame_b_d;
   logic              frame_err_q, frame_err_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              op_word_bad;
   logic              op_is_arith;
   logic [WORD_W-1:0] result_a;
   logic [WORD_W-1:0] result_b;

   // Decode the op word and form the outgoing operands from the word now arriving as B
   always_comb begin
      op_word_bad = (word_data[WORD_W-1:OP_W] != '0);
      op_is_arith = (op_q == OP_W'(0)) || (op_q == OP_W'(1));
      result_a    = a_q;
      result_b    = word_data;
      if (op_q == OP_W'(0)) begin
         result_a = a_q + word_data;
      end else if (op_q == OP_W'(1)) begin
         result_a = a_q - word_data;
      end
      if (op_is_arith) begin
         result_b = '0;
      end
   end

   // Next-state logic: word sequencing, inter-word timer, handshake and error reporting
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      timer_d       = timer_q;
      frame_valid_d = frame_valid_q;
      frame_op_d    = frame_op_q;
      frame_a_d     = frame_a_q;
      frame_b_d     = frame_b_q;
      frame_err_d   = 1'b0;
      err_code_d    = err_code_q;

      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (word_valid) begin
               if (op_word_bad) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_BAD_OP;
               end else begin
                  op_d    = word_data[OP_W-1:0];
                  state_d = GET_A;
               end
            end
         end
         GET_A: begin
            if (word_valid) begin
               a_d     = word_data;
               timer_d = '0;
               state_d = GET_B;
            end else if (timer_q == TMR_LAST) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
               op_d        = '0;
               timer_d     = '0;
               state_d     = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         GET_B: begin
            if (word_valid) begin
               b_d           = word_data;
               frame_valid_d = 1'b1;
               frame_op_d    = op_q;
               frame_a_d     = result_a;
               frame_b_d     = result_b;
               timer_d       = '0;
               state_d       = HOLD;
            end else if (timer_q == TMR_LAST) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
               op_d        = '0;
               a_d         = '0;
               timer_d     = '0;
               state_d     = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         HOLD: begin
            if (word_valid) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_OVERRUN;
            end
            if (frame_valid_q && frame_ready) begin
               frame_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         timer_q       <= '0;
         frame_valid_q <= 1'b0;
         frame_op_q    <= '0;
         frame_a_q     <= '0;
         frame_b_q     <= '0;
         frame_err_q   <= 1'b0;
         err_code_q    <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         a_q           <= a_d;
         b_q           <= b_d;
         timer_q       <= timer_d;
         frame_valid_q <= frame_valid_d;
         frame_op_q    <= frame_op_d;
         frame_a_q     <= frame_a_d;
         frame_b_q     <= frame_b_d;
         frame_err_q   <= frame_err_d;
         err_code_q    <= err_code_d;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      frame_valid = frame_valid_q;
      frame_op    = frame_op_q;
      frame_a     = frame_a_q;
      frame_b     = frame_b_q;
      frame_err   = frame_err_q;
      err_code    = err_code_q;
      busy        = (state_q != IDLE);
      state_out   = state_q;
   end

endmodule

// File: tb/tb_i2c_slave_frame_assembler.sv
// tb_i2c_slave_frame_assembler
// Directed bench for the frame assembler with a short inter-word timeout.
module tb_i2c_slave_frame_assembler;

   localparam int WORD_W      = 32;
   localparam int OP_W        = 2;
   localparam int TIMEOUT_CYC = 100;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              word_valid = 1'b0;
   logic [WORD_W-1:0] word_data = '0;
   logic              frame_ready = 1'b0;
   logic              frame_valid;
   logic [OP_W-1:0]   frame_op;
   logic [WORD_W-1:0] frame_a;
   logic [WORD_W-1:0] frame_b;
   logic              frame_err;
   logic [1:0]        err_code;
   logic              busy;
   logic [1:0]        state_out;

   int total = 0;
   int bad   = 0;

   i2c_slave_frame_assembler #(
      .WORD_W     (WORD_W),
      .OP_W       (OP_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .word_valid (word_valid),
      .word_data  (word_data),
      .frame_ready(frame_ready),
      .frame_valid(frame_valid),
      .frame_op   (frame_op),
      .frame_a    (frame_a),
      .frame_b    (frame_b),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .busy       (busy),
      .state_out  (state_out)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single cycle
   task automatic applyStimulus(input logic [WORD_W-1:0] data);
      word_valid = 1'b1;
      word_data  = data;
      tick();
      word_valid = 1'b0;
      word_data  = '0;
   endtask

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [WORD_W-1:0] observed,
                              input logic [WORD_W-1:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence covering handshake, errors, timeout and reset
   initial begin
      logic hold_ok;

      tick();
      tick();
      checkOutput("rst_valid", 32'(frame_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_errcode", 32'(err_code), 32'd0);
      reset = 1'b0;
      tick();

      // 1. raw op frame with ready already high
      frame_ready = 1'b1;
      applyStimulus(32'h0000_0002);
      checkOutput("t1_state_a", 32'(state_out), 32'd1);
      applyStimulus(32'h3F80_0000);
      checkOutput("t1_state_b", 32'(state_out), 32'd2);
      applyStimulus(32'h4000_0000);
      checkOutput("t1_valid", 32'(frame_valid), 32'd1);
      checkOutput("t1_op", 32'(frame_op), 32'd2);
      checkOutput("t1_a", frame_a, 32'h3F80_0000);
      checkOutput("t1_b", frame_b, 32'h4000_0000);
      tick();
      checkOutput("t1_valid_drop", 32'(frame_valid), 32'd0);
      checkOutput("t1_state_idle", 32'(state_out), 32'd0);
      checkOutput("t1_a_kept", frame_a, 32'h3F80_0000);

      // 2. same frame held 50 cycles by backpressure
      frame_ready = 1'b0;
      applyStimulus(32'h0000_0002);
      applyStimulus(32'h3F80_0000);
      applyStimulus(32'h4000_0000);
      hold_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!(frame_valid === 1'b1 && frame_a === 32'h3F80_0000 &&
               frame_b === 32'h4000_0000 && frame_op === 2'd2 && busy === 1'b1))
            hold_ok = 1'b0;
         tick();
      end
      checkOutput("t2_held_50", 32'(hold_ok), 32'd1);
      frame_ready = 1'b1;
      checkOutput("t2_valid_pre", 32'(frame_valid), 32'd1);
      tick();
      checkOutput("t2_valid_post", 32'(frame_valid), 32'd0);
      checkOutput("t2_busy_post", 32'(busy), 32'd0);

      // 3. bad op word, then a subtract frame
      applyStimulus(32'h0000_0105);
      checkOutput("t3_err", 32'(frame_err), 32'd1);
      checkOutput("t3_code", 32'(err_code), 32'd1);
      checkOutput("t3_state", 32'(state_out), 32'd0);
      tick();
      checkOutput("t3_err_pulse", 32'(frame_err), 32'd0);
      checkOutput("t3_code_held", 32'(err_code), 32'd1);
      applyStimulus(32'h0000_0001);
      applyStimulus(32'h4040_0000);
      applyStimulus(32'h0000_0000);
      checkOutput("t3_valid", 32'(frame_valid), 32'd1);
      checkOutput("t3_op", 32'(frame_op), 32'd1);
      checkOutput("t3_a", frame_a, 32'h4040_0000);
      checkOutput("t3_b", frame_b, 32'd0);
      tick();

      // 4. timeout in GET_B at cycle 99
      applyStimulus(32'h0000_0002);
      applyStimulus(32'h0000_00AA);
      for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
      checkOutput("t4_state_99", 32'(state_out), 32'd2);
      checkOutput("t4_noerr_99", 32'(frame_err), 32'd0);
      tick();
      checkOutput("t4_err", 32'(frame_err), 32'd1);
      checkOutput("t4_code", 32'(err_code), 32'd2);
      checkOutput("t4_state", 32'(state_out), 32'd0);
      tick();

      // 4b. word exactly at cycle 99 wins, then an add frame
      applyStimulus(32'h0000_0000);
      for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
      checkOutput("t4b_state_99", 32'(state_out), 32'd1);
      applyStimulus(32'h0000_0005);
      checkOutput("t4b_state", 32'(state_out), 32'd2);
      checkOutput("t4b_noerr", 32'(frame_err), 32'd0);
      applyStimulus(32'h0000_0003);
      checkOutput("t4b_op", 32'(frame_op), 32'd0);
      checkOutput("t4b_a_sum", frame_a, 32'd8);
      checkOutput("t4b_b", frame_b, 32'd0);
      tick();

      // 5. overrun while holding a subtract frame
      frame_ready = 1'b0;
      applyStimulus(32'h0000_0001);
      applyStimulus(32'h0000_000A);
      applyStimulus(32'h0000_0003);
      checkOutput("t5_a_diff", frame_a, 32'd7);
      tick();
      applyStimulus(32'h0000_DEAD);
      checkOutput("t5_err", 32'(frame_err), 32'd1);
      checkOutput("t5_code", 32'(err_code), 32'd3);
      checkOutput("t5_valid", 32'(frame_valid), 32'd1);
      checkOutput("t5_a_kept", frame_a, 32'd7);
      checkOutput("t5_state", 32'(state_out), 32'd3);
      frame_ready = 1'b1;
      tick();
      checkOutput("t5_released", 32'(frame_valid), 32'd0);
      applyStimulus(32'h0000_0003);
      applyStimulus(32'h0000_0011);
      applyStimulus(32'h0000_0022);
      checkOutput("t5_next_op", 32'(frame_op), 32'd3);
      checkOutput("t5_next_a", frame_a, 32'h11);
      checkOutput("t5_next_b", frame_b, 32'h22);
      tick();

      // 6. asynchronous reset in GET_B
      applyStimulus(32'h0000_0002);
      applyStimulus(32'h0000_1234);
      checkOutput("t6_state_b", 32'(state_out), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_state", 32'(state_out), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_a", frame_a, 32'd0);
      checkOutput("t6_b", frame_b, 32'd0);
      checkOutput("t6_op", 32'(frame_op), 32'd0);
      checkOutput("t6_code", 32'(err_code), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      applyStimulus(32'h0000_0002);
      applyStimulus(32'h0000_0055);
      applyStimulus(32'h0000_0066);
      checkOutput("t6_valid", 32'(frame_valid), 32'd1);
      checkOutput("t6_new_a", frame_a, 32'h55);
      checkOutput("t6_new_b", frame_b, 32'h66);
      checkOutput("t6_new_op", 32'(frame_op), 32'd2);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
